// File: rtl/astro_pkg.sv
// Shared constants, pixel/window/position types and FSM encoding for the
// template-matching datapath.
package astro_pkg;
  localparam int WIN       = 16;
  localparam int PIX_W     = 8;
  localparam int POS_LAST  = 64;
  localparam int SAD_W     = 16;
  localparam int ROW_W     = 12;
  localparam int POS_COUNT = (POS_LAST + 1) * (POS_LAST + 1);

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [WIN-1:0][WIN-1:0][PIX_W-1:0] win_t;
  typedef logic [6:0] pos_t;

  typedef struct packed {
    pos_t row;
    pos_t col;
  } pos_tag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } sad_state_t;
endpackage

// File: rtl/sad_match_engine_sad_tree.sv
// Three-stage registered SAD tree: per-pixel |w - t|, per-row sums, total.
// The position tag rides alongside the valid bit so results stay attributable.
module sad_tree
  import astro_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  win_t             window,
  input  win_t             tmpl,
  input  logic             vld,
  input  pos_tag_t         tag,
  output logic [SAD_W-1:0] sad,
  output logic             sad_vld,
  output pos_tag_t         sad_tag
);

  function automatic pix_t abs_diff(input pix_t a, input pix_t b);
    logic signed [PIX_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[PIX_W] ? pix_t'(-d) : pix_t'(d);
  endfunction

  function automatic logic [ROW_W-1:0] row_sum(input logic [WIN-1:0][PIX_W-1:0] r);
    logic [ROW_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WIN; i++) acc = acc + ROW_W'(r[i]);
    return acc;
  endfunction

  function automatic logic [SAD_W-1:0] total_sum(input logic [WIN-1:0][ROW_W-1:0] rows);
    logic [SAD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WIN; i++) acc = acc + SAD_W'(rows[i]);
    return acc;
  endfunction

  win_t                        ad_p0;
  logic                        vld_p0;
  pos_tag_t                    tag_p0;
  logic [WIN-1:0][ROW_W-1:0]   row_p1;
  logic                        vld_p1;
  pos_tag_t                    tag_p1;
  logic [SAD_W-1:0]            sad_p2;
  logic                        vld_p2;
  pos_tag_t                    tag_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= vld;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage p0: absolute differences
  always_ff @(posedge clk) begin
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        ad_p0[r][c] <= abs_diff(window[r][c], tmpl[r][c]);
    tag_p0 <= tag;
  end

  // Stage p1: row sums
  always_ff @(posedge clk) begin
    for (int r = 0; r < WIN; r++) row_p1[r] <= row_sum(ad_p0[r]);
    tag_p1 <= tag_p0;
  end

  // Stage p2: window total
  always_ff @(posedge clk) begin
    sad_p2 <= total_sum(row_p1);
    tag_p2 <= tag_p1;
  end

  assign sad     = sad_p2;
  assign sad_vld = vld_p2;
  assign sad_tag = tag_p2;

endmodule

// File: rtl/sad_match_engine.sv
// Template matcher: streams 16x16 windows through the SAD tree, tracks the
// minimum SAD with its grid position and reports it once the stream drains.
module sad_match_engine
  import astro_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  win_t             template_data,
  input  win_t             window_data,
  input  logic             window_ready,
  input  logic             window_done,
  output logic             receive,
  output logic             busy,
  output logic             result_valid,
  output logic [SAD_W-1:0] best_sad,
  output pos_t             best_row,
  output pos_t             best_col,
  output logic             count_err
);

  sad_state_t       state, state_nx;
  win_t             tmpl;
  pos_t             pos_row, pos_col;
  logic [12:0]      accept_cnt;
  logic [1:0]       drain_cnt;
  logic             accept, start_ok, drain_end;
  logic [SAD_W-1:0] sad, track_sad;
  logic             sad_vld;
  pos_tag_t         sad_tag, track_pos;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (window_ready && window_done) state_nx = DRAIN;
      DRAIN:   if (drain_end) state_nx = REPORT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept       = (state == RUN) && window_ready;
    start_ok     = (state == IDLE) && start;
    busy         = (state == RUN) || (state == DRAIN);
    result_valid = (state == REPORT);
    drain_end    = (state == DRAIN) && (drain_cnt == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (start_ok) tmpl <= template_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt  <= '0;
      pos_row    <= '0;
      pos_col    <= '0;
      accept_cnt <= '0;
      count_err  <= 1'b0;
      receive    <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      receive   <= accept;
      if (start_ok) begin
        pos_row    <= '0;
        pos_col    <= '0;
        accept_cnt <= '0;
        count_err  <= 1'b0;
      end else if (accept) begin
        if (pos_col == pos_t'(POS_LAST)) begin
          pos_col <= '0;
          pos_row <= (pos_row == pos_t'(POS_LAST)) ? pos_t'(0) : pos_row + pos_t'(1);
        end else begin
          pos_col <= pos_col + pos_t'(1);
        end
        // Saturate the count once exhausted; any further window is an error.
        if (accept_cnt == 13'(POS_COUNT)) count_err <= 1'b1;
        else                               accept_cnt <= accept_cnt + 13'd1;
        if (window_done && accept_cnt != 13'(POS_COUNT - 1)) count_err <= 1'b1;
      end
    end
  end

  sad_tree u_tree (
    .clk     (clk),
    .rst     (rst),
    .window  (window_data),
    .tmpl    (tmpl),
    .vld     (accept),
    .tag     ('{row: pos_row, col: pos_col}),
    .sad     (sad),
    .sad_vld (sad_vld),
    .sad_tag (sad_tag)
  );

  // Compare stage: strict less-than keeps the earliest position on ties
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      track_sad <= '1;
      track_pos <= '0;
    end else if (sad_vld && sad < track_sad) begin
      track_sad <= sad;
      track_pos <= sad_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_sad <= '0;
      best_row <= '0;
      best_col <= '0;
    end else if (drain_end) begin
      best_sad <= track_sad;
      best_row <= track_pos.row;
      best_col <= track_pos.col;
    end
  end

endmodule

// File: tb/tb_sad_match_engine.sv
// Directed bench for sad_match_engine: table of whole-stream scenarios plus
// hand-written reset-abort and idle-ignore sequences.
module tb_sad_match_engine;
  import astro_pkg::*;

  logic             clk = 1'b0;
  logic             rst, start, window_ready, window_done;
  win_t             template_data, window_data;
  logic             receive, busy, result_valid, count_err;
  logic [SAD_W-1:0] best_sad;
  pos_t             best_row, best_col;

  int checks = 0;
  int errors = 0;

  sad_match_engine dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .template_data (template_data),
    .window_data   (window_data),
    .window_ready  (window_ready),
    .window_done   (window_done),
    .receive       (receive),
    .busy          (busy),
    .result_valid  (result_valid),
    .best_sad      (best_sad),
    .best_row      (best_row),
    .best_col      (best_col),
    .count_err     (count_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tpl;
    logic [7:0]  win;
    logic [7:0]  sp_val;
    int          sp_row;
    int          sp_col;
    int          n;
    int          gap;
    logic [15:0] e_sad;
    int          e_row;
    int          e_col;
    logic        e_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input string tag, input vec_t v);
    int rcv, extra, lat;
    int r, c;
    template_data = {256{v.tpl}};
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);
    rcv = 0;
    extra = 0;
    for (int i = 0; i < v.n; i++) begin
      r = i / 65;
      c = i % 65;
      window_data  = (r == v.sp_row && c == v.sp_col) ? {256{v.sp_val}} : {256{v.win}};
      window_ready = 1'b1;
      window_done  = (i == v.n - 1);
      tick();
      window_ready = 1'b0;
      window_done  = 1'b0;
      if (receive) rcv++;
      if (i != v.n - 1)
        for (int g = 1; g < v.gap; g++) begin
          tick();
          if (receive) extra++;
        end
    end
    check({tag, " receive_count"}, rcv, v.n);
    check({tag, " receive_extra"}, extra, 0);
    lat = 11;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (result_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, " result_latency_ok"}, (lat >= 3 && lat <= 4), 1);
    check({tag, " best_sad"}, best_sad, v.e_sad);
    check({tag, " best_row"}, best_row, v.e_row);
    check({tag, " best_col"}, best_col, v.e_col);
    check({tag, " count_err"}, count_err, v.e_err);
    check({tag, " busy_at_report"}, busy, 0);
    tick();
    check({tag, " result_valid_pulse"}, result_valid, 0);
    check({tag, " best_sad_held"}, best_sad, v.e_sad);
  endtask

  initial begin
    vec_t post;
    // identical stream, first tie wins
    vecs[0] = '{8'h10, 8'h10, 8'h00, -1, -1, 4225, 2, 16'd0,     0,  0,  1'b0};
    // unique minimum, back-to-back windows
    vecs[1] = '{8'h00, 8'h01, 8'h00, 37, 52, 4225, 1, 16'd0,     37, 52, 1'b0};
    // maximum SAD everywhere
    vecs[2] = '{8'h00, 8'hFF, 8'h00, -1, -1, 4225, 1, 16'd65280, 0,  0,  1'b0};
    // short stream: done on the 100th window
    vecs[3] = '{8'h00, 8'h01, 8'h00, 1,  30, 100,  2, 16'd0,     1,  30, 1'b1};
    // one window past the grid: tag wraps, tie keeps (0,0)
    vecs[4] = '{8'h00, 8'h01, 8'h00, -1, -1, 4226, 1, 16'd256,   0,  0,  1'b1};
    // mixed sign differences: default |0x70-0x80|=16 per pixel, special 8
    vecs[5] = '{8'h80, 8'h70, 8'h88, 20, 30, 4225, 2, 16'd2048,  20, 30, 1'b0};
    post    = '{8'h00, 8'h01, 8'h00, 64, 64, 4225, 2, 16'd0,     64, 64, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    window_ready = 1'b0;
    window_done = 1'b0;
    template_data = '0;
    window_data = '0;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset result_valid", result_valid, 0);
    check("reset receive", receive, 0);
    check("reset best_sad", best_sad, 0);
    check("reset count_err", count_err, 0);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) run_stream($sformatf("vec%0d", t), vecs[t]);

    // Abort a search midway with reset
    template_data = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      window_data  = '0;
      window_ready = 1'b1;
      tick();
      window_ready = 1'b0;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort best_sad", best_sad, 0);
    check("abort best_row", best_row, 0);
    check("abort best_col", best_col, 0);
    check("abort count_err", count_err, 0);
    check("abort result_valid", result_valid, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (result_valid) check("abort no_result", result_valid, 0);
    end

    // window_ready while idle is ignored
    window_ready = 1'b1;
    window_done = 1'b1;
    tick();
    window_ready = 1'b0;
    window_done = 1'b0;
    check("idle receive", receive, 0);
    check("idle busy", busy, 0);
    tick();

    run_stream("post_reset", post);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sad_match_engine.md
Name: sad_match_engine

Overview:
- Downstream consumer of the 16x16 window stream produced by the window loader.
- Compares each 16x16 window against a latched 16x16 template using the sum of absolute differences (SAD), over a 65x65 grid of positions in an 80x80 search area.
- Tracks the minimum SAD and its (row, col) and reports the best match once the stream completes.
- Fully pipelined, one window per cycle; the upstream delivers at most one window every 2 cycles.

Parameters:
- WIN, 16: window/template edge in pixels.
- PIX_W, 8: pixel width in bits.
- POS_LAST, 64: last valid row/col window offset; grid is (POS_LAST+1)^2 = 4225 positions.
- SAD_W, 16: SAD accumulator width; 256*255 = 65280 fits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; latches template_data and begins a search.
- template_data  in  [15:0][15:0][7:0]  reference template; sampled only on an accepted start.
- window_data  in  [15:0][15:0][7:0]  candidate window from the loader.
- window_ready  in  1  window_data valid this cycle; single-cycle pulse with no backpressure.
- window_done  in  1  asserted with the final window of the stream.
- receive  out  1  one-cycle pulse, the cycle after each accepted window.
- busy  out  1  high from accepted start until result_valid.
- result_valid  out  1  one-cycle pulse when the best_* outputs are final.
- best_sad  out  SAD_W  minimum SAD found.
- best_row  out  7  window row offset of the minimum.
- best_col  out  7  window col offset of the minimum.
- count_err  out  1  sticky until next start; window count at done was not 4225, or a window arrived after the count was exhausted.

Behaviour:
- Reset: every output is 0, state IDLE, counters 0, best_sad = 16'hFFFF internally. Reset mid-search aborts and discards everything; no result_valid is issued.
- States:
  - IDLE: start -> RUN (latch template, clear counters, best_sad = FFFF, clear count_err).
  - RUN: accept a window on every cycle window_ready = 1. Accepting a window with window_done = 1 -> DRAIN.
  - DRAIN: wait until the pipeline is empty (3 cycles after the last accept) -> REPORT.
  - REPORT: result_valid = 1 for one cycle, busy = 0 -> IDLE.
- start outside IDLE is ignored. window_ready in IDLE, DRAIN or REPORT is ignored (no receive).
- Position tagging:
  - Position counters pos_row/pos_col advance row-major on each accept: col 0..64, then wrap to 0 with row+1.
  - The tag travels with the data through the pipeline.
- Pipeline (latency 3 cycles from accept to compare):
  - S1: 256 registered |w - t|, 8 bits each.
  - S2: 16 registered row sums, 12 bits each.
  - S3: registered total, SAD_W bits.
  - Compare stage: if total < best_sad, update best_sad/row/col.
  - Ties keep the earlier position (strict less-than).
- No arithmetic saturation is needed; widths are exact.
- The best_* outputs hold their values after REPORT until the next start.
- count_err is set in these cases:
  - window_done arrives with accept count != 4225.
  - An accept occurs beyond position (64,64); such a window is still compared, and its tag wraps to (0,0).
- window_done without window_ready has no effect.

Decomposition:
- Shared package astro_pkg:
  - WIN, PIX_W, POS_LAST, SAD_W constants.
  - pix_t, win_t ([15:0][15:0][7:0]) and pos_t (7-bit) typedefs.
  - The sad_state_t enum.
- One sub-module, sad_tree: the 3-stage registered abs-diff/adder tree. Inputs are the window, template and a valid+tag; outputs are the SAD, valid and tag.
- The FSM, position counters and best tracker stay in the top level.

Test Plan:
- Identical stream: template all 8'h10; 4225 windows all 8'h10, window_ready every 2nd cycle, done on the last -> best_sad = 0, best (0,0) (first tie), result_valid 3-4 cycles after the last accept, count_err = 0.
- Unique minimum: template all 8'h00; every window all 8'h01 (SAD 256) except position (37,52), whose window is all 8'h00 -> best_sad = 0, best_row = 37, best_col = 52.
- Max SAD: template all 8'h00, all windows 8'hFF -> best_sad = 65280, best (0,0), no overflow.
- Short stream: done asserted on the 100th window -> result_valid issued, count_err = 1, best reflects the first 100 windows only.
- Reset mid-RUN at window 2000 -> all outputs 0 next cycle; a fresh start with a full stream produces a correct result with no stale best.
- Back-to-back windows: window_ready held high for 4225 cycles -> every window is accepted and receive pulses 4225 times, each 1 cycle after its accept.
